fifo_wptr_full: RTL
===================

FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 SHALL have parameter add_width, default 3: memory address width.
REQ-002 SHALL have parameter fifo_depth, default 8: entry count, fixed at 2**add_width.
REQ-003 SHALL have parameter af_margin, default 2: almost-full margin in entries; used only with the REQ-024 macro.
REQ-004 SHALL have port w_clk, input, 1: write-domain clock; single clock for the whole block.
REQ-005 SHALL have port w_rst, input, 1: reset, synchronous to w_clk, active-high.
REQ-006 SHALL have port w_inc, input, 1: write request from the producer.
REQ-007 SHALL have port r_ptr_gray, input, add_width+1: Gray read pointer from the read domain, unsynchronized.
REQ-008 SHALL have port w_addr, output, add_width: memory write address, the low bits of the binary write pointer.
REQ-009 SHALL have port w_ptr_gray, output, add_width+1: registered Gray write pointer sent to the read domain.
REQ-010 SHALL have port w_full, output, 1: registered full flag, driven to the memory and the producer.
REQ-011 SHALL have port w_almost_full, output, 1: registered almost-full flag; present only with the REQ-024 macro.

Function
REQ-012 SHALL synchronize r_ptr_gray through two w_clk flops into rq2; no other logic reads r_ptr_gray directly.
REQ-013 SHALL hold a registered binary pointer wbin of add_width+1 bits; write accepted = w_inc && !w_full.
REQ-014 SHALL compute wbin_next = wbin + 1 on an accepted write, else wbin, modulo 2**(add_width+1), wrapping from all-ones to 0.
REQ-015 SHALL register w_ptr_gray = wbin_next ^ (wbin_next >> 1) on every edge, so it changes by at most one bit per edge.
REQ-016 SHALL drive w_addr = wbin[add_width-1:0]; the address advances on the same edge that accepts the write.
REQ-017 SHALL register w_full = (gray(wbin_next) == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}).
REQ-018 w_full SHALL assert on the edge that accepts the write filling the last free entry.
REQ-019 SHALL ignore w_inc while w_full=1: wbin, w_addr and w_ptr_gray hold their values.
REQ-020 A change on r_ptr_gray SHALL reach w_full on the third w_clk edge after it is stable: two sync edges plus one flag edge.
REQ-021 Full detection SHALL be pessimistic only: it SHALL never report not-full while the FIFO holds fifo_depth entries.

Reset
REQ-022 While w_rst=1 at a w_clk edge, the block SHALL clear wbin, w_addr, w_ptr_gray, w_full, w_almost_full and both sync stages to 0.
REQ-023 w_rst SHALL override a simultaneous w_inc; a reset during an active write burst discards that write, and operation resumes from address 0.

Configuration
REQ-024 Macro FIFO_WPTR_ALMOST_FULL_EN defined: the block SHALL convert rq2 from Gray to binary (rbin_s).
REQ-025 With that macro, the block SHALL register w_almost_full = ((wbin_next - rbin_s) mod 2**(add_width+1)) >= fifo_depth - af_margin.
REQ-026 Macro not defined: the w_almost_full port, the Gray-to-binary logic and the subtractor SHALL be absent; all other behaviour is identical.

Structure
REQ-027 A shared package fifo_pkg SHALL hold the bin2gray and gray2bin functions and the pointer-width constant PTR_W = add_width+1, shared with the read-side block.
REQ-028 The two-flop synchronizer SHALL be the sub-module ptr_sync_2ff, parameterized by width; the same module serves the read side.

Verification
REQ-029 Reset: hold w_rst=1 for 2 edges with w_inc=1 -> w_addr=0, w_ptr_gray=4'b0000, w_full=0.
REQ-030 Fill: hold r_ptr_gray=0, apply 8 consecutive w_inc -> w_addr steps 0..7 then 0; w_ptr_gray=4'b1100; w_full=1 on the 8th accepting edge.
REQ-031 Overflow block: while full, hold w_inc=1 for 3 edges -> w_addr=0, w_ptr_gray=4'b1100, w_full=1, all unchanged.
REQ-032 Drain release: while full, change r_ptr_gray 0000->0001 -> w_full=0 on the 3rd edge after; the next w_inc is accepted with w_addr=0.
REQ-033 Wrap: perform 20 writes with r_ptr_gray tracking 2 entries behind -> wbin wraps 1111->0000, w_ptr_gray goes 1000->0000, w_full stays 0.
REQ-034 Almost-full, macro defined: 6 writes with r_ptr_gray=0 -> w_almost_full=1 on the 6th edge; w_almost_full=0 after the 5th edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO write and read sides.
// Gray/binary conversions work on 32-bit words; callers cast to their pointer width.
package fifo_pkg;

  localparam int ADD_WIDTH_DEFAULT = 3;
  localparam int PTR_W             = ADD_WIDTH_DEFAULT + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bits above the caller's width arrive as zero, so they do not disturb the low bits.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the clk domain.
// Shared by the write-side and read-side pointer blocks.
module ptr_sync_2ff #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] stage1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag logic of an async FIFO.
// Optional almost-full flag is built only when FIFO_WPTR_ALMOST_FULL_EN is defined.
//
// Handshake: w_inc is a request; it is accepted on a w_clk edge only when w_full
// is low at that edge. A refused request has no effect and need not be held.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int add_width  = 3,
  parameter int fifo_depth = 8,
  parameter int af_margin  = 2
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_inc,
  input  logic [add_width:0]   r_ptr_gray,
  output logic [add_width-1:0] w_addr,
  output logic [add_width:0]   w_ptr_gray,
`ifdef FIFO_WPTR_ALMOST_FULL_EN
  output logic                 w_almost_full,
`endif
  output logic                 w_full
);

  localparam int PW = add_width + 1;

  if ((fifo_depth != (1 << add_width)) || (af_margin < 0) || (af_margin > fifo_depth)) begin : g_param_check
    $error("fifo_wptr_full: fifo_depth must be 2**add_width and af_margin within 0..fifo_depth");
  end

  logic [PW-1:0] rq2;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] full_match;
  logic          w_accept;
  logic          full_next;

  ptr_sync_2ff #(
    .width (PW)
  ) u_rptr_sync (
    .clk (w_clk),
    .rst (w_rst),
    .d   (r_ptr_gray),
    .q   (rq2)
  );

  assign w_accept   = w_inc && !w_full;
  assign wbin_next  = wbin + {{(PW-1){1'b0}}, w_accept};
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));
  assign w_addr     = wbin[add_width-1:0];

  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign full_match = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
  assign full_next  = (wgray_next == full_match);

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wbin       <= '0;
      w_ptr_gray <= '0;
      w_full     <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      w_ptr_gray <= wgray_next;
      w_full     <= full_next;
    end
  end

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_THRESH = PW'(fifo_depth - af_margin);

  logic [PW-1:0] rbin_s;
  logic [PW-1:0] occupancy;

  assign rbin_s    = PW'(gray2bin(32'(rq2)));
  assign occupancy = wbin_next - rbin_s;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_almost_full <= 1'b0;
    end else begin
      w_almost_full <= (occupancy >= AF_THRESH);
    end
  end
`endif

endmodule
